load_data_extender: RTL and testbench
=====================================

LOAD_DATA_EXTENDER -- requirements
Module: load_data_extender

Interface
REQ-001 SHALL have parameter XLEN, default 32, datapath width; legal values 32 and 64.
REQ-002 SHALL have parameter OFFW, default $clog2(XLEN/8), byte-offset width (derived, not overridden).
REQ-003 SHALL have port clk  input  1  sole clock, rising-edge.
REQ-004 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port in_valid  input  1  upstream load beat valid.
REQ-006 SHALL have port in_ready  output  1  block can accept a beat.
REQ-007 SHALL have port in_data  input  XLEN  raw memory read word.
REQ-008 SHALL have port in_funct3  input  3  RISC-V load funct3.
REQ-009 SHALL have port in_addr_lo  input  OFFW  low address bits (byte offset in word).
REQ-010 SHALL have port out_valid  output  1  result valid.
REQ-011 SHALL have port out_ready  input  1  downstream accepts result.
REQ-012 SHALL have port out_data  output  XLEN  extended load result.
REQ-013 SHALL have port out_fault  output  1  misaligned-load flag for current result.

Function
REQ-014 SHALL transfer input on clk edge when in_valid && in_ready; output consumed when out_valid && out_ready.
REQ-015 SHALL buffer up to 2 results in FIFO order; states EMPTY, ONE, FULL; push only -> next state up, pop only -> next state down, push+pop -> unchanged.
REQ-016 SHALL drive in_ready = 1 in EMPTY and ONE, 0 in FULL, from registered state only (no combinational path from out_ready).
REQ-017 SHALL present a beat accepted in EMPTY on out_valid in the next cycle (latency 1).
REQ-018 SHALL hold out_data and out_fault stable while out_valid && !out_ready.
REQ-019 SHALL compute result as: shift in_data right by 8*in_addr_lo, take low 8/16/32/64 bits, extend to XLEN.
REQ-020 SHALL decode funct3: 000 LB sign, 001 LH sign, 010 LW sign, 100 LBU zero, 101 LHU zero; at XLEN=64 additionally 011 LD, 110 LWU zero.
REQ-021 SHALL produce out_data = 0, out_fault = 0 for funct3 111, and for 011/110 when XLEN=32.
REQ-022 SHALL treat as misaligned: LH/LHU with addr_lo[0]=1; LW/LWU with addr_lo[1:0]!=0; LD with addr_lo!=0.
REQ-023 SHALL compute extension at enqueue time; stored results unaffected by later input changes.

Reset
REQ-024 SHALL, on rising clk with rst_n=0, go to EMPTY: out_valid=0, out_data=0, out_fault=0; in_ready=1 from the first cycle after reset.
REQ-025 SHALL discard buffered results and ignore in_valid during reset; reset mid-transfer loses all entries.

Configuration
REQ-026 SHALL honour macro LOAD_EXT_MISALIGN_TRAP_EN.
REQ-027 With LOAD_EXT_MISALIGN_TRAP_EN defined: misaligned beat yields out_fault=1, out_data=0, still occupies one buffer slot.
REQ-028 Without it: offset bits below natural alignment forced to 0 before shifting; out_fault tied 0.

Verification
REQ-029 XLEN=32, in_data=0x8000_80F0, LB addr_lo=0 -> next cycle out_data=0xFFFF_FFF0, out_fault=0.
REQ-030 XLEN=32, in_data=0x8000_80F0, LHU addr_lo=2 -> out_data=0x0000_8000; LH addr_lo=2 -> 0xFFFF_8000.
REQ-031 XLEN=64, in_data=0x8765_4321_0000_0000, LWU addr_lo=4 -> 0x0000_0000_8765_4321; LW -> 0xFFFF_FFFF_8765_4321.
REQ-032 out_ready=0, push 3 beats back-to-back -> in_ready low after 2nd accept; then out_ready=1 -> beats emerge in order, in_ready high the cycle after first pop.
REQ-033 LW addr_lo=1: with macro -> out_fault=1, out_data=0; without -> data of word at offset 0, out_fault=0.
REQ-034 FULL state, assert rst_n=0 one cycle -> out_valid=0, out_data=0, in_ready=1 next cycle, no stale beats appear.

Source files
------------

// File: rtl/load_data_extender.sv
// load_data_extender: aligns and sign/zero-extends a raw memory read word
// according to the RISC-V load funct3, then queues the result in a
// two-entry FIFO with a registered valid/ready handshake on both sides.
//
// Optional build macro: LOAD_EXT_MISALIGN_TRAP_EN
//   defined   -> misaligned loads produce out_fault=1, out_data=0
//   undefined -> offset bits below natural alignment are ignored, out_fault=0
//
// Ports
//   clk         in   sole clock, rising edge
//   rst_n       in   synchronous active-low reset
//   in_valid    in   upstream load beat valid
//   in_ready    out  block can accept a beat (registered, from state only)
//   in_data     in   raw memory read word, XLEN bits
//   in_funct3   in   RISC-V load funct3
//   in_addr_lo  in   byte offset of the access within the word
//   out_valid   out  result valid
//   out_ready   in   downstream accepts result
//   out_data    out  extended load result, XLEN bits
//   out_fault   out  misaligned-load flag for the current result

module load_data_extender #(
   parameter int unsigned XLEN = 32,
   parameter int unsigned OFFW = $clog2(XLEN / 8)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [XLEN-1:0]   in_data,
   input  logic [2:0]        in_funct3,
   input  logic [OFFW-1:0]   in_addr_lo,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [XLEN-1:0]   out_data,
   output logic              out_fault
);

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      FULL  = 2'd2
   } state_t;

   typedef enum logic [1:0] {
      SZ_B = 2'd0,
      SZ_H = 2'd1,
      SZ_W = 2'd2,
      SZ_D = 2'd3
   } size_t;

   state_t            state;
   size_t             size;
   logic              sext;
   logic              legal;
   logic [OFFW-1:0]   align_mask;
   logic [OFFW-1:0]   eff_off;
   logic [XLEN-1:0]   shifted;
   logic [XLEN-1:0]   ext_data;
   logic              fill;
   logic [XLEN-1:0]   new_data;
   logic              new_fault;
   logic [XLEN-1:0]   tail_data;
   logic              tail_fault;
   logic              push;
   logic              pop;

   // funct3 decode: access size, signedness, and whether the encoding exists
   always_comb begin
      size  = SZ_B;
      sext  = 1'b0;
      legal = 1'b1;
      case (in_funct3)
         3'b000: begin size = SZ_B; sext = 1'b1; end
         3'b001: begin size = SZ_H; sext = 1'b1; end
         3'b010: begin size = SZ_W; sext = 1'b1; end
         3'b011: begin size = SZ_D; legal = (XLEN == 64); end
         3'b100: begin size = SZ_B; end
         3'b101: begin size = SZ_H; end
         3'b110: begin size = SZ_W; legal = (XLEN == 64); end
         default: begin legal = 1'b0; end
      endcase
   end

   // offset bits that must be zero for a naturally aligned access
   always_comb begin
      case (size)
         SZ_B:    align_mask = '0;
         SZ_H:    align_mask = OFFW'(1);
         SZ_W:    align_mask = OFFW'(3);
         default: align_mask = '1;
      endcase
   end

   assign eff_off = in_addr_lo & ~align_mask;
   assign shifted = in_data >> {eff_off, 3'b000};

   // fill the whole word with the extension bit, then overlay the loaded bits
   always_comb begin
      fill     = 1'b0;
      ext_data = '0;
      case (size)
         SZ_B: begin
            fill          = sext & shifted[7];
            ext_data      = {XLEN{fill}};
            ext_data[7:0] = shifted[7:0];
         end
         SZ_H: begin
            fill           = sext & shifted[15];
            ext_data       = {XLEN{fill}};
            ext_data[15:0] = shifted[15:0];
         end
         SZ_W: begin
            fill           = sext & shifted[31];
            ext_data       = {XLEN{fill}};
            ext_data[31:0] = shifted[31:0];
         end
         default: begin
            ext_data = shifted;
         end
      endcase
      if (!legal) begin
         ext_data = '0;
      end
   end

`ifdef LOAD_EXT_MISALIGN_TRAP_EN
   logic misaligned;
   assign misaligned = legal & (|(in_addr_lo & align_mask));
   assign new_fault  = misaligned;
   assign new_data   = misaligned ? '0 : ext_data;
`else
   assign new_fault  = 1'b0;
   assign new_data   = ext_data;
`endif

   assign push = in_valid & in_ready;
   assign pop  = out_valid & out_ready;

   // two-entry FIFO: out_data/out_fault hold the head, tail_* the second entry
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state      <= EMPTY;
         in_ready   <= 1'b1;
         out_valid  <= 1'b0;
         out_data   <= '0;
         out_fault  <= 1'b0;
         tail_data  <= '0;
         tail_fault <= 1'b0;
      end else begin
         case (state)
            EMPTY: begin
               if (push) begin
                  out_data  <= new_data;
                  out_fault <= new_fault;
                  out_valid <= 1'b1;
                  state     <= ONE;
               end
            end
            ONE: begin
               if (push && pop) begin
                  out_data  <= new_data;
                  out_fault <= new_fault;
               end else if (push) begin
                  tail_data  <= new_data;
                  tail_fault <= new_fault;
                  in_ready   <= 1'b0;
                  state      <= FULL;
               end else if (pop) begin
                  out_valid <= 1'b0;
                  state     <= EMPTY;
               end
            end
            FULL: begin
               // in_ready is low here, so only a pop can happen
               if (pop) begin
                  out_data  <= tail_data;
                  out_fault <= tail_fault;
                  in_ready  <= 1'b1;
                  state     <= ONE;
               end
            end
            default: begin
               state     <= EMPTY;
               in_ready  <= 1'b1;
               out_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_load_data_extender.sv
// Self-checking bench for load_data_extender: one XLEN=32 and one XLEN=64
// instance share the same handshake stimulus; each has its own reference queue.

module tb_load_data_extender;

   logic        clk;
   logic        rst_n;
   logic        vld;
   logic        rdy;
   logic [2:0]  f3;
   logic [63:0] d64;
   logic [2:0]  a3;

   logic [31:0] d32;
   logic [1:0]  a2;
   assign d32 = d64[31:0];
   assign a2  = a3[1:0];

   logic        in_ready32, out_valid32, out_fault32;
   logic [31:0] out_data32;
   logic        in_ready64, out_valid64, out_fault64;
   logic [63:0] out_data64;

   int checks;
   int errors;
   bit started;

   logic [64:0] q32[$];
   logic [64:0] q64[$];

   load_data_extender #(.XLEN(32)) dut32 (
      .clk(clk), .rst_n(rst_n),
      .in_valid(vld), .in_ready(in_ready32),
      .in_data(d32), .in_funct3(f3), .in_addr_lo(a2),
      .out_valid(out_valid32), .out_ready(rdy),
      .out_data(out_data32), .out_fault(out_fault32)
   );

   load_data_extender #(.XLEN(64)) dut64 (
      .clk(clk), .rst_n(rst_n),
      .in_valid(vld), .in_ready(in_ready64),
      .in_data(d64), .in_funct3(f3), .in_addr_lo(a3),
      .out_valid(out_valid64), .out_ready(rdy),
      .out_data(out_data64), .out_fault(out_fault64)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference: {fault, data} for one load, computed from the ISA rules.
   function automatic logic [64:0] ref_load(int xlen, logic [63:0] d,
                                            logic [2:0] fn, int off);
      int n;
      bit s;
      bit ok;
      logic [63:0] v;
      logic [63:0] m;
      n = 1; s = 0; ok = 1;
      case (fn)
         3'd0: begin n = 1; s = 1; end
         3'd1: begin n = 2; s = 1; end
         3'd2: begin n = 4; s = 1; end
         3'd3: begin n = 8; ok = (xlen == 64); end
         3'd4: begin n = 1; end
         3'd5: begin n = 2; end
         3'd6: begin n = 4; ok = (xlen == 64); end
         default: ok = 0;
      endcase
      if (!ok) return 65'd0;
`ifdef LOAD_EXT_MISALIGN_TRAP_EN
      if ((off % n) != 0) return {1'b1, 64'd0};
`endif
      off = off - (off % n);
      v = d >> (8 * off);
      if (n < 8) begin
         m = (64'd1 << (8 * n)) - 64'd1;
         v = v & m;
         if (s && v[8 * n - 1]) v = v | ~m;
      end
      if (xlen == 32) v = v & 64'h0000_0000_FFFF_FFFF;
      return {1'b0, v};
   endfunction

   task automatic chk(string tag, logic [64:0] obs, logic [64:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Check current outputs against the model, update the model, advance one clock.
   task automatic cycle();
      bit can_push;
      if (started) begin
         chk("in_ready32", 65'(in_ready32), 65'(q32.size() < 2));
         chk("in_ready64", 65'(in_ready64), 65'(q64.size() < 2));
         chk("out_valid32", 65'(out_valid32), 65'(q32.size() != 0));
         chk("out_valid64", 65'(out_valid64), 65'(q64.size() != 0));
         if (q32.size() != 0) chk("result32", {out_fault32, 32'h0, out_data32}, q32[0]);
         if (q64.size() != 0) chk("result64", {out_fault64, out_data64}, q64[0]);
      end
      if (!rst_n) begin
         q32.delete();
         q64.delete();
      end else begin
         can_push = (q32.size() < 2);
         if (rdy && q32.size() != 0) void'(q32.pop_front());
         if (rdy && q64.size() != 0) void'(q64.pop_front());
         if (vld && can_push) begin
            q32.push_back(ref_load(32, {32'h0, d64[31:0]}, f3, int'(a3[1:0])));
            q64.push_back(ref_load(64, d64, f3, int'(a3)));
         end
      end
      @(posedge clk);
      #1;
      started = 1'b1;
   endtask

   task automatic beat(logic [2:0] fn, logic [63:0] d, logic [2:0] a);
      vld = 1'b1; f3 = fn; d64 = d; a3 = a;
      cycle();
      vld = 1'b0;
   endtask

   initial begin
      checks = 0; errors = 0; started = 1'b0;
      rst_n = 1'b0; vld = 1'b0; rdy = 1'b1; f3 = 3'd0; d64 = '0; a3 = '0;

      cycle();
      cycle();
      rst_n = 1'b1;
      chk("reset_valid32", 65'(out_valid32), 65'd0);
      chk("reset_data32", {out_fault32, 32'h0, out_data32}, 65'd0);
      chk("reset_ready32", 65'(in_ready32), 65'd1);
      chk("reset_valid64", 65'(out_valid64), 65'd0);
      chk("reset_data64", {out_fault64, out_data64}, 65'd0);
      chk("reset_ready64", 65'(in_ready64), 65'd1);

      // LB sign extension, latency 1
      beat(3'b000, 64'h0000_0000_8000_80F0, 3'd0);
      chk("lb_valid", 65'(out_valid32), 65'd1);
      chk("lb_data", {out_fault32, 32'h0, out_data32}, 65'h0_0000_0000_FFFF_FFF0);
      cycle();

      beat(3'b101, 64'h0000_0000_8000_80F0, 3'd2);
      chk("lhu_data", {out_fault32, 32'h0, out_data32}, 65'h0_0000_0000_0000_8000);
      cycle();
      beat(3'b001, 64'h0000_0000_8000_80F0, 3'd2);
      chk("lh_data", {out_fault32, 32'h0, out_data32}, 65'h0_0000_0000_FFFF_8000);
      cycle();

      beat(3'b110, 64'h8765_4321_0000_0000, 3'd4);
      chk("lwu64_data", {out_fault64, out_data64}, 65'h0_0000_0000_8765_4321);
      cycle();
      beat(3'b010, 64'h8765_4321_0000_0000, 3'd4);
      chk("lw64_data", {out_fault64, out_data64}, 65'h0_FFFF_FFFF_8765_4321);
      cycle();

      beat(3'b111, 64'hFFFF_FFFF_FFFF_FFFF, 3'd0);
      chk("f3_111_32", {out_fault32, 32'h0, out_data32}, 65'd0);
      chk("f3_111_64", {out_fault64, out_data64}, 65'd0);
      cycle();
      beat(3'b011, 64'hFFFF_FFFF_FFFF_FFFF, 3'd0);
      chk("ld_on_32", {out_fault32, 32'h0, out_data32}, 65'd0);
      chk("ld_on_64", {out_fault64, out_data64}, 65'h0_FFFF_FFFF_FFFF_FFFF);
      cycle();

      // misaligned LW
      beat(3'b010, 64'h1122_3344_AABB_CCDD, 3'd1);
`ifdef LOAD_EXT_MISALIGN_TRAP_EN
      chk("lw_mis32", {out_fault32, 32'h0, out_data32}, {1'b1, 64'd0});
      chk("lw_mis64", {out_fault64, out_data64}, {1'b1, 64'd0});
`else
      chk("lw_mis32", {out_fault32, 32'h0, out_data32}, 65'h0_0000_0000_AABB_CCDD);
      chk("lw_mis64", {out_fault64, out_data64}, 65'h0_FFFF_FFFF_AABB_CCDD);
`endif
      cycle();

      // backpressure: three beats with out_ready low
      rdy = 1'b0;
      beat(3'b100, 64'h0000_0000_0000_0011, 3'd0);
      chk("bp_ready1", 65'(in_ready32), 65'd1);
      beat(3'b100, 64'h0000_0000_0000_0022, 3'd0);
      chk("bp_ready2", 65'(in_ready32), 65'd0);
      beat(3'b100, 64'h0000_0000_0000_0033, 3'd0);
      chk("bp_hold", {out_fault32, 32'h0, out_data32}, 65'h11);
      rdy = 1'b1;
      cycle();
      chk("bp_ready_after_pop", 65'(in_ready32), 65'd1);
      chk("bp_second", {out_fault32, 32'h0, out_data32}, 65'h22);
      cycle();
      cycle();

      // reset while FULL
      rdy = 1'b0;
      beat(3'b010, 64'h0000_0000_1234_5678, 3'd0);
      beat(3'b010, 64'h0000_0000_9ABC_DEF0, 3'd0);
      rst_n = 1'b0; vld = 1'b1;
      cycle();
      chk("rst_full_valid", 65'(out_valid32), 65'd0);
      chk("rst_full_data", {out_fault32, 32'h0, out_data32}, 65'd0);
      chk("rst_full_ready", 65'(in_ready32), 65'd1);
      chk("rst_full_valid64", 65'(out_valid64), 65'd0);
      rst_n = 1'b1; vld = 1'b0; rdy = 1'b1;
      cycle();
      cycle();

      // randomized traffic
      for (int i = 0; i < 600; i++) begin
         vld = ($urandom_range(0, 3) != 0);
         rdy = ($urandom_range(0, 2) != 0);
         f3  = 3'($urandom_range(0, 7));
         a3  = 3'($urandom_range(0, 7));
         d64 = {$urandom, $urandom};
         cycle();
      end

      // drain with a bounded wait
      vld = 1'b0; rdy = 1'b1;
      for (int i = 0; i < 10 && q32.size() != 0; i++) cycle();
      cycle();
      chk("drain_valid32", 65'(out_valid32), 65'd0);
      chk("drain_valid64", 65'(out_valid64), 65'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
